// File: rtl/mux_ft_pkg.sv
// Shared types and widths for the redundant-channel failover controller.
package mux_ft_pkg;

    localparam int CNT_W   = 4;
    localparam int SWCNT_W = 8;

    typedef enum logic [1:0] {
        USE0 = 2'd0,
        USE1 = 2'd1,
        DEAD = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/chan_health.sv
// Per-channel health tracker: even-parity check, consecutive error/good
// counters and the registered FAIL flag with hysteresis.
module chan_health
    import mux_ft_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int FAIL_THRESH    = 3,
    parameter int RECOVER_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             p,
    input  logic             v,
    output logic             good,
    output logic             fail
);

    localparam logic [CNT_W-1:0] FAIL_MAX  = CNT_W'(FAIL_THRESH);
    localparam logic [CNT_W-1:0] FAIL_LAST = CNT_W'(FAIL_THRESH - 1);
    localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(RECOVER_THRESH - 1);

    logic             perr;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] good_cnt;

    // An invalid word is neither good nor bad: both terms are gated by v.
    assign perr = v & (^{d, p});
    assign good = v & ~perr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            good_cnt <= '0;
            fail     <= 1'b0;
        end else if (fail && good && good_cnt == REC_LAST) begin
            fail     <= 1'b0;
            err_cnt  <= '0;
            good_cnt <= '0;
        end else if (perr) begin
            if (err_cnt != FAIL_MAX) err_cnt <= err_cnt + 1'b1;
            if (err_cnt >= FAIL_LAST) fail <= 1'b1;
            good_cnt <= '0;
        end else if (good) begin
            err_cnt <= '0;
            if (fail) good_cnt <= good_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_failover_ctrl.sv
// Two-channel redundant data selector: health-driven failover with manual
// force override, registered output data and a saturating switch counter.
module mux_failover_ctrl
    import mux_ft_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int FAIL_THRESH    = 3,
    parameter int RECOVER_THRESH = 4
) (
    input  logic               CK,
    input  logic               RN,
    input  logic [WIDTH-1:0]   D0,
    input  logic [WIDTH-1:0]   D1,
    input  logic               P0,
    input  logic               P1,
    input  logic               V0,
    input  logic               V1,
    input  logic               FORCE_EN,
    input  logic               FORCE_SL,
    output logic [WIDTH-1:0]   Z,
    output logic               ZV,
    output logic               SL,
    output logic               FAIL0,
    output logic               FAIL1,
    output logic               ALARM,
    output logic [SWCNT_W-1:0] SWCNT
);

    ctrl_state_t state;
    ctrl_state_t nxt;
    logic        good0;
    logic        good1;
    logic        sel_good;
    logic        switch_evt;

    chan_health #(
        .WIDTH(WIDTH), .FAIL_THRESH(FAIL_THRESH), .RECOVER_THRESH(RECOVER_THRESH)
    ) u_ch0 (
        .clk(CK), .rst_n(RN), .d(D0), .p(P0), .v(V0), .good(good0), .fail(FAIL0)
    );

    chan_health #(
        .WIDTH(WIDTH), .FAIL_THRESH(FAIL_THRESH), .RECOVER_THRESH(RECOVER_THRESH)
    ) u_ch1 (
        .clk(CK), .rst_n(RN), .d(D1), .p(P1), .v(V1), .good(good1), .fail(FAIL1)
    );

    // Transitions look only at the registered FAIL flags, so SL lags them by one cycle.
    // NOTE: nxt gets a default before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        nxt = state;
        if (FORCE_EN) begin
            nxt = FORCE_SL ? USE1 : USE0;
        end else begin
            case (state)
                USE0: if (FAIL0 && FAIL1) nxt = DEAD;
                      else if (FAIL0)     nxt = USE1;
                USE1: if (FAIL0 && FAIL1) nxt = DEAD;
                      else if (FAIL1)     nxt = USE0;
                DEAD: if (!FAIL0)         nxt = USE0;
                      else if (!FAIL1)    nxt = USE1;
                default:                  nxt = USE0;
            endcase
        end
    end

    // Only direct USE0<->USE1 moves count; entering or leaving DEAD does not.
    assign switch_evt = (state == USE0 && nxt == USE1) || (state == USE1 && nxt == USE0);
    assign sel_good   = SL ? good1 : good0;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= USE0;
            SL    <= 1'b0;
            ALARM <= 1'b0;
            SWCNT <= '0;
            Z     <= '0;
            ZV    <= 1'b0;
        end else begin
            state <= nxt;
            ALARM <= (nxt == DEAD);
            if (nxt == USE0)      SL <= 1'b0;
            else if (nxt == USE1) SL <= 1'b1;

            if (switch_evt && SWCNT != '1) SWCNT <= SWCNT + 1'b1;

            if (state != DEAD && sel_good) begin
                Z  <= SL ? D1 : D0;
                ZV <= 1'b1;
            end else begin
                ZV <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_failover_ctrl.sv
// Directed, table-driven bench for mux_failover_ctrl (WIDTH=8, thresholds 3/4).
module tb_mux_failover_ctrl;

    logic       CK = 1'b0;
    logic       RN;
    logic [7:0] D0, D1;
    logic       P0, P1, V0, V1, FORCE_EN, FORCE_SL;
    logic [7:0] Z;
    logic       ZV, SL, FAIL0, FAIL1, ALARM;
    logic [7:0] SWCNT;

    mux_failover_ctrl #(.WIDTH(8), .FAIL_THRESH(3), .RECOVER_THRESH(4)) dut (
        .CK(CK), .RN(RN), .D0(D0), .D1(D1), .P0(P0), .P1(P1), .V0(V0), .V1(V1),
        .FORCE_EN(FORCE_EN), .FORCE_SL(FORCE_SL), .Z(Z), .ZV(ZV), .SL(SL),
        .FAIL0(FAIL0), .FAIL1(FAIL1), .ALARM(ALARM), .SWCNT(SWCNT)
    );

    always #5 CK = ~CK;

    typedef struct packed {
        logic [7:0] z;
        logic       zv, sl, f0, f1, al;
        logic [7:0] sw;
    } outs_t;

    typedef struct packed {
        logic [7:0] d0;
        logic       b0, v0;
        logic [7:0] d1;
        logic       b1, v1, fe, fs;
        outs_t      exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic outs_t o(input int z, zv, sl, f0, f1, al, sw);
        outs_t r;
        r.z = 8'(z); r.zv = 1'(zv); r.sl = 1'(sl);
        r.f0 = 1'(f0); r.f1 = 1'(f1); r.al = 1'(al); r.sw = 8'(sw);
        return r;
    endfunction

    // b0/b1 = 1 means send the word with a deliberately wrong parity bit.
    function automatic vec_t mk(input int d0, b0, v0, d1, b1, v1, fe, fs, input outs_t e);
        vec_t r;
        r.d0 = 8'(d0); r.b0 = 1'(b0); r.v0 = 1'(v0);
        r.d1 = 8'(d1); r.b1 = 1'(b1); r.v1 = 1'(v1);
        r.fe = 1'(fe); r.fs = 1'(fs); r.exp = e;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        D0 = v.d0; P0 = (^v.d0) ^ v.b0; V0 = v.v0;
        D1 = v.d1; P1 = (^v.d1) ^ v.b1; V1 = v.v1;
        FORCE_EN = v.fe; FORCE_SL = v.fs;
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = {Z, ZV, SL, FAIL0, FAIL1, ALARM, SWCNT};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got z=%h zv=%b sl=%b f0=%b f1=%b al=%b sw=%0d, want z=%h zv=%b sl=%b f0=%b f1=%b al=%b sw=%0d",
                     name, act.z, act.zv, act.sl, act.f0, act.f1, act.al, act.sw,
                     exp.z, exp.zv, exp.sl, exp.f0, exp.f1, exp.al, exp.sw);
        end
    endtask

    task automatic do_reset();
        RN = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0)));
        #2;
        check("reset", o(0, 0, 0, 0, 0, 0, 0));
        @(negedge CK);
        RN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // good traffic, then two bad + one good (no failover)
        vecs.push_back(mk('h11,0,1, 'h22,0,1, 0,0, o('h11,1,0,0,0,0,0)));
        vecs.push_back(mk('h33,0,1, 'h44,0,1, 0,0, o('h33,1,0,0,0,0,0)));
        vecs.push_back(mk('h55,1,1, 'h66,0,1, 0,0, o('h33,0,0,0,0,0,0)));
        vecs.push_back(mk('h55,1,1, 'h66,0,1, 0,0, o('h33,0,0,0,0,0,0)));
        vecs.push_back(mk('h77,0,1, 'h88,0,1, 0,0, o('h77,1,0,0,0,0,0)));
        // three bad ch0 words -> FAIL0, SL=1 one cycle later
        vecs.push_back(mk('h01,1,1, 'h02,0,1, 0,0, o('h77,0,0,0,0,0,0)));
        vecs.push_back(mk('h01,1,1, 'h02,0,1, 0,0, o('h77,0,0,0,0,0,0)));
        vecs.push_back(mk('h01,1,1, 'h0a,0,1, 0,0, o('h77,0,0,1,0,0,0)));
        vecs.push_back(mk('h01,1,1, 'h0b,0,1, 0,0, o('h77,0,1,1,0,0,1)));
        vecs.push_back(mk('h01,1,1, 'h2c,0,1, 0,0, o('h2c,1,1,1,0,0,1)));
        // fail ch1 too -> DEAD
        vecs.push_back(mk('h01,1,1, 'h3c,1,1, 0,0, o('h2c,0,1,1,0,0,1)));
        vecs.push_back(mk('h01,1,1, 'h3c,1,1, 0,0, o('h2c,0,1,1,0,0,1)));
        vecs.push_back(mk('h01,1,1, 'h3c,1,1, 0,0, o('h2c,0,1,1,1,0,1)));
        vecs.push_back(mk('h01,1,1, 'h3c,1,1, 0,0, o('h2c,0,1,1,1,1,1)));
        // four good ch1 words recover ch1; DEAD blocks ZV meanwhile
        vecs.push_back(mk('h01,1,1, 'h5a,0,1, 0,0, o('h2c,0,1,1,1,1,1)));
        vecs.push_back(mk('h01,1,1, 'h5a,0,1, 0,0, o('h2c,0,1,1,1,1,1)));
        vecs.push_back(mk('h01,1,1, 'h5a,0,1, 0,0, o('h2c,0,1,1,1,1,1)));
        vecs.push_back(mk('h01,1,1, 'h5a,0,1, 0,0, o('h2c,0,1,1,0,1,1)));
        vecs.push_back(mk('h01,1,1, 'h6b,0,1, 0,0, o('h2c,0,1,1,0,0,1)));
        vecs.push_back(mk('h01,1,1, 'h7e,0,1, 0,0, o('h7e,1,1,1,0,0,1)));
        // ch0 recovers; no automatic revert
        vecs.push_back(mk('h10,0,1, 'h21,0,1, 0,0, o('h21,1,1,1,0,0,1)));
        vecs.push_back(mk('h10,0,1, 'h32,0,1, 0,0, o('h32,1,1,1,0,0,1)));
        vecs.push_back(mk('h10,0,1, 'h43,0,1, 0,0, o('h43,1,1,1,0,0,1)));
        vecs.push_back(mk('h10,0,1, 'h54,0,1, 0,0, o('h54,1,1,0,0,0,1)));
        vecs.push_back(mk('h10,0,1, 'h65,0,1, 0,0, o('h65,1,1,0,0,0,1)));
        // force back to ch0
        vecs.push_back(mk('h99,0,1, 'haa,0,1, 1,0, o('haa,1,0,0,0,0,2)));
        vecs.push_back(mk('hbb,0,1, 'hcc,0,1, 1,0, o('hbb,1,0,0,0,0,2)));
        // ch1 fails while forced; then force onto the failed channel
        vecs.push_back(mk('hc1,0,1, 'hd1,1,1, 1,0, o('hc1,1,0,0,0,0,2)));
        vecs.push_back(mk('hc1,0,1, 'hd1,1,1, 1,0, o('hc1,1,0,0,0,0,2)));
        vecs.push_back(mk('hc2,0,1, 'hd1,1,1, 1,0, o('hc2,1,0,0,1,0,2)));
        vecs.push_back(mk('hc3,0,1, 'hd4,1,1, 1,1, o('hc3,1,1,0,1,0,3)));
        vecs.push_back(mk('hc5,0,1, 'he5,1,1, 1,1, o('hc3,0,1,0,1,0,3)));
        vecs.push_back(mk('hc6,0,1, 'hf6,0,1, 1,1, o('hf6,1,1,0,1,0,3)));
        // release force: FAIL1 still set -> back to USE0
        vecs.push_back(mk('hc7,0,1, 'h12,0,1, 0,0, o('h12,1,0,0,1,0,4)));
        vecs.push_back(mk('hc8,0,0, 'h13,0,0, 0,0, o('h12,0,0,0,1,0,4)));

        do_reset();
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            tick();
            check($sformatf("vec%0d", k), vecs[k].exp);
        end

        // Reset pulsed in the cycle FAIL0 sets: pending switch must be dropped.
        do_reset();
        drive(mk('h11,0,1, 'h22,0,1, 0,0, o(0,0,0,0,0,0,0)));
        tick();
        drive(mk('h11,1,1, 'h22,0,1, 0,0, o(0,0,0,0,0,0,0)));
        tick();
        tick();
        tick();
        check("fail0_set", o('h11,0,0,1,0,0,0));
        RN = 1'b0;
        drive(mk('h5c,0,1, 'h22,0,1, 0,0, o(0,0,0,0,0,0,0)));
        #1;
        check("async_reset", o(0,0,0,0,0,0,0));
        @(negedge CK);
        RN = 1'b1;
        tick();
        check("post_reset_1", o('h5c,1,0,0,0,0,0));
        tick();
        check("post_reset_2", o('h5c,1,0,0,0,0,0));

        // Forced toggling saturates SWCNT at 255.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(mk(0,0,0, 0,0,0, 1, (i % 2 == 0) ? 1 : 0, o(0,0,0,0,0,0,0)));
            tick();
            if (i == 9)   check("swcnt_10",  o(0,0,0,0,0,0,10));
            if (i == 253) check("swcnt_254", o(0,0,0,0,0,0,254));
            if (i == 254) check("swcnt_255", o(0,0,1,0,0,0,255));
            if (i == 299) check("swcnt_sat", o(0,0,0,0,0,0,255));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mux_failover_ctrl.md
MUX_FAILOVER_CTRL -- requirements
Module: mux_failover_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data width of each redundant channel.
REQ-002 Parameter FAIL_THRESH, default 3: consecutive parity errors that declare a channel failed; legal range 1..15.
REQ-003 Parameter RECOVER_THRESH, default 4: consecutive good words that clear a channel failure; legal range 1..15.
REQ-004 CK  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 RN  input  1  reset; asynchronous assertion, active-low.
REQ-006 D0 / D1  input  WIDTH  redundant channel 0 / 1 data.
REQ-007 P0 / P1  input  1  even-parity bit for D0 / D1.
REQ-008 V0 / V1  input  1  channel 0 / 1 word valid.
REQ-009 FORCE_EN  input  1  manual select override enable.
REQ-010 FORCE_SL  input  1  channel forced when FORCE_EN=1.
REQ-011 Z  output  WIDTH  registered selected data.
REQ-012 ZV  output  1  Z valid strobe.
REQ-013 SL  output  1  active channel select; 0=channel 0, 1=channel 1.
REQ-014 FAIL0 / FAIL1  output  1  channel failed flags.
REQ-015 ALARM  output  1  both channels failed.
REQ-016 SWCNT  output  8  saturating count of channel switches.

Function
REQ-017 Parity error perrN SHALL be VN & (^{DN,PN} == 1); a word with VN=0 SHALL be neither good nor bad.
REQ-018 Per channel, a 4-bit error counter SHALL increment on perrN, saturate at FAIL_THRESH, and clear on a good word (VN & !perrN).
REQ-019 FAILN SHALL set on the edge at which the FAIL_THRESH-th consecutive error is sampled.
REQ-020 While FAILN=1, a 4-bit good counter SHALL increment on good words and clear on perrN; FAILN and both counters SHALL clear on the edge at which the RECOVER_THRESH-th consecutive good word is sampled.
REQ-021 Controller states SHALL be USE0 (SL=0), USE1 (SL=1) and DEAD (SL holds last value, ALARM=1).
REQ-022 Transitions SHALL use registered FAIL flags, so SL changes one cycle after the FAIL flag changes.
REQ-023 USE0 -> USE1 when FAIL0 & !FAIL1; USE0 -> DEAD when FAIL0 & FAIL1; USE1 is symmetric.
REQ-024 DEAD -> USE0 when !FAIL0, else DEAD -> USE1 when !FAIL1; channel 0 SHALL win when both recover together.
REQ-025 There SHALL be no automatic revert; USE1 SHALL remain when FAIL0 clears.
REQ-026 FORCE_EN=1 SHALL override health: next state USE<FORCE_SL>, from any state including DEAD.
REQ-027 FAIL flags and counters SHALL keep updating during force.
REQ-028 Z SHALL load D<SL> and ZV SHALL assert one cycle later when V<SL>=1, perr<SL>=0 and state != DEAD; otherwise ZV=0 and Z SHALL hold.
REQ-029 SWCNT SHALL increment on every USE0<->USE1 change, including forced changes, and saturate at 255; entries into and exits from DEAD SHALL not count.

Reset
REQ-030 RN=0 SHALL asynchronously set state USE0, SL=0, Z=0, ZV=0, FAIL0=FAIL1=0, ALARM=0, SWCNT=0 and all counters to 0; release is synchronized externally.
REQ-031 Reset asserted mid-failover SHALL abandon any pending transition; the first post-reset edge SHALL behave as from power-up.

Structure
REQ-032 Package mux_ft_pkg SHALL hold the state enum (USE0, USE1, DEAD), the counter width constant (4) and SWCNT width (8).
REQ-033 Per-channel parity check, error/good counters and FAIL flag SHALL be one sub-module, chan_health, instantiated twice.

Verification (WIDTH=8, FAIL_THRESH=3, RECOVER_THRESH=4)
REQ-034 Reset, then both channels send good words 0x11/0x22 -> SL=0, Z=0x11 with ZV=1 one cycle after each word, SWCNT=0.
REQ-035 Three consecutive bad-parity words on ch0 -> FAIL0=1 after the third, SL=1 next cycle, Z follows D1, SWCNT=1; two bad words then one good word -> no failover.
REQ-036 Fail ch0 then ch1 -> ALARM=1, ZV=0; four good ch1 words -> FAIL1=0, state USE1, ALARM=0, SWCNT unchanged.
REQ-037 In USE1 with ch0 recovered, FORCE_EN=1, FORCE_SL=0 -> SL=0 next cycle, SWCNT+1; force to a failed channel -> SL follows force, ZV=0 on bad words.
REQ-038 RN pulsed low the cycle FAIL0 sets -> all outputs 0 immediately, no switch after release; 300 forced toggles -> SWCNT=255.
